// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache between the fetch stage and the
// memory instruction port. On a miss it refills a whole 4-word line.
module icache_direct #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned INDEX_BITS = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             cpu_read,
    input  logic [WORD_SIZE-1:0]             cpu_address,
    output logic [WORD_SIZE-1:0]             cpu_data,
    output logic                             cpu_ready,
    output logic                             mem_read,
    output logic [WORD_SIZE-1:0]             mem_address,
    input  logic [WORD_SIZE*LINE_WORDS-1:0]  mem_data,
    input  logic                             mem_input_ready,
    input  logic                             mem_ready,
    output logic [WORD_SIZE-1:0]             num_access,
    output logic [WORD_SIZE-1:0]             num_miss
);

    localparam int unsigned LINES     = 1 << INDEX_BITS;
    localparam int unsigned OFF_BITS  = 2;
    localparam int unsigned TAG_BITS  = WORD_SIZE - OFF_BITS - INDEX_BITS;
    localparam int unsigned LINE_BITS = WORD_SIZE * LINE_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [TAG_BITS-1:0]    tag_d  [LINES];
    logic [LINE_BITS-1:0]   data_q [LINES];
    logic [LINE_BITS-1:0]   data_d [LINES];
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [WORD_SIZE-1:0]   num_access_q, num_access_d;
    logic [WORD_SIZE-1:0]   num_miss_q, num_miss_d;

    logic [OFF_BITS-1:0]    cur_off, fill_off;
    logic [INDEX_BITS-1:0]  cur_idx, fill_idx;
    logic [TAG_BITS-1:0]    cur_tag, fill_tag;
    logic                   hit;

    function automatic logic [WORD_SIZE-1:0] sel_word(input logic [LINE_BITS-1:0] line,
                                                      input logic [OFF_BITS-1:0]  off);
        return line[off*WORD_SIZE +: WORD_SIZE];
    endfunction

    assign cur_off  = cpu_address[OFF_BITS-1:0];
    assign cur_idx  = cpu_address[OFF_BITS+INDEX_BITS-1:OFF_BITS];
    assign cur_tag  = cpu_address[WORD_SIZE-1:OFF_BITS+INDEX_BITS];
    assign fill_off = addr_q[OFF_BITS-1:0];
    assign fill_idx = addr_q[OFF_BITS+INDEX_BITS-1:OFF_BITS];
    assign fill_tag = addr_q[WORD_SIZE-1:OFF_BITS+INDEX_BITS];
    assign hit      = cpu_read & valid_q[cur_idx] & (tag_q[cur_idx] == cur_tag);

    // Next-state, array update and the same-cycle cpu response.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        addr_d       = addr_q;
        flush_pend_d = flush_pend_q;
        num_access_d = num_access_q;
        num_miss_d   = num_miss_q;
        cpu_ready    = 1'b0;
        cpu_data     = '0;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (hit) begin
                    cpu_ready    = 1'b1;
                    cpu_data     = sel_word(data_q[cur_idx], cur_off);
                    num_access_d = num_access_q + WORD_SIZE'(1);
                end else if (cpu_read) begin
                    addr_d     = cpu_address;
                    num_miss_d = num_miss_q + WORD_SIZE'(1);
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                flush_pend_d = flush_pend_q | flush;
                if (mem_input_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                flush_pend_d = flush_pend_q | flush;
                if (mem_ready) begin
                    valid_d[fill_idx] = 1'b1;
                    tag_d[fill_idx]   = fill_tag;
                    data_d[fill_idx]  = mem_data;
                    state_d           = S_FILL;
                end
            end
            S_FILL: begin
                // The miss was already counted; only a still-waiting fetch completes.
                if (cpu_read) begin
                    cpu_ready    = 1'b1;
                    cpu_data     = sel_word(data_q[fill_idx], fill_off);
                    num_access_d = num_access_q + WORD_SIZE'(1);
                end
                if (flush_pend_q | flush) begin
                    valid_d = '0;
                end
                flush_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (reset) begin
            cpu_ready = 1'b0;
            cpu_data  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            addr_q       <= '0;
            flush_pend_q <= 1'b0;
            num_access_q <= '0;
            num_miss_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
            num_access_q <= num_access_d;
            num_miss_q   <= num_miss_d;
        end
    end

    assign mem_read    = (state_q == S_REQ);
    assign mem_address = {addr_q[WORD_SIZE-1:OFF_BITS], OFF_BITS'(0)};
    assign num_access  = num_access_q;
    assign num_miss    = num_miss_q;

endmodule

// File: tb/tb_icache_direct.sv
// Randomized bench for icache_direct against a line-level cache model and a
// flat backing memory.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        cpu_read;
    logic [15:0] cpu_address;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [63:0] mem_data;
    logic        mem_input_ready;
    logic        mem_ready;
    logic [15:0] num_access;
    logic [15:0] num_miss;

    always #5 clk = ~clk;

    icache_direct dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .cpu_read        (cpu_read),
        .cpu_address     (cpu_address),
        .cpu_data        (cpu_data),
        .cpu_ready       (cpu_ready),
        .mem_read        (mem_read),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_input_ready (mem_input_ready),
        .mem_ready       (mem_ready),
        .num_access      (num_access),
        .num_miss        (num_miss)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [63:0] mem_lines [0:16383];
    bit          ref_valid [4];
    logic [11:0] ref_tag   [4];
    logic [15:0] ref_access;
    logic [15:0] ref_miss;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_hit(input logic [15:0] a);
        logic [1:0] idx;
        idx = a[3:2];
        return ref_valid[idx] && (ref_tag[idx] == a[15:4]);
    endfunction

    function automatic logic [15:0] word_of(input logic [15:0] a);
        logic [63:0] line;
        line = mem_lines[a[15:2]];
        return line[a[1:0]*16 +: 16];
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_num_access"}, 64'(num_access), 64'(ref_access));
        check_eq({tag, "_num_miss"},   64'(num_miss),   64'(ref_miss));
    endtask

    // One fetch; on a miss, acc_dly refused REQ cycles and mem_dly empty WAIT cycles.
    task automatic fetch(input logic [15:0] a, input int acc_dly, input int mem_dly,
                         input bit drop, input bit flush_wait);
        logic [15:0] la;
        la = {a[15:2], 2'b00};
        @(posedge clk); #1;
        cpu_read        = 1'b1;
        cpu_address     = a;
        mem_input_ready = 1'($urandom_range(0, 1));
        mem_ready       = 1'b0;
        #4;
        if (ref_hit(a)) begin
            check_eq("hit_ready", 64'(cpu_ready), 64'd1);
            check_eq("hit_data",  64'(cpu_data),  64'(word_of(a)));
            check_eq("hit_no_mem_read", 64'(mem_read), 64'd0);
            ref_access = ref_access + 16'd1;
        end else begin
            check_eq("miss_idle_ready", 64'(cpu_ready), 64'd0);
            ref_miss = ref_miss + 16'd1;
            for (int k = 0; k <= acc_dly; k++) begin
                @(posedge clk); #1;
                if (drop && k == 0) cpu_read = 1'b0;
                cpu_address     = 16'($urandom);
                mem_input_ready = (k == acc_dly);
                mem_ready       = ($urandom_range(0, 3) == 0);
                mem_data        = {$urandom, $urandom};
                #4;
                check_eq("req_mem_read",    64'(mem_read),    64'd1);
                check_eq("req_mem_address", 64'(mem_address), 64'(la));
                check_eq("req_cpu_ready",   64'(cpu_ready),   64'd0);
            end
            for (int d = 0; d <= mem_dly; d++) begin
                @(posedge clk); #1;
                mem_input_ready = 1'($urandom_range(0, 1));
                flush           = flush_wait && (d == 0);
                mem_ready       = (d == mem_dly);
                mem_data        = (d == mem_dly) ? mem_lines[la[15:2]] : {$urandom, $urandom};
                #4;
                check_eq("wait_mem_read",  64'(mem_read),  64'd0);
                check_eq("wait_cpu_ready", 64'(cpu_ready), 64'd0);
            end
            ref_valid[a[3:2]] = 1'b1;
            ref_tag[a[3:2]]   = a[15:4];
            @(posedge clk); #1;
            flush       = 1'b0;
            mem_ready   = 1'b0;
            mem_data    = {$urandom, $urandom};
            cpu_address = a;
            #4;
            if (drop) begin
                check_eq("fill_dropped_ready", 64'(cpu_ready), 64'd0);
            end else begin
                check_eq("fill_ready", 64'(cpu_ready), 64'd1);
                check_eq("fill_data",  64'(cpu_data),  64'(word_of(a)));
                ref_access = ref_access + 16'd1;
            end
            if (flush_wait) ref_clear();
        end
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        #4;
        check_counters("post_fetch");
        check_eq("idle_mem_read", 64'(mem_read), 64'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    // Flush in IDLE; presents a would-be hit when one exists to show it is suppressed.
    task automatic flush_idle(input logic [15:0] a);
        @(posedge clk); #1;
        flush       = 1'b1;
        cpu_address = a;
        cpu_read    = ref_hit(a);
        #4;
        check_eq("flush_hit_suppressed", 64'(cpu_ready), 64'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        cpu_read = 1'b0;
        ref_clear();
        #4;
        check_counters("post_flush");
    endtask

    task automatic reset_mid_wait();
        flush_idle(16'h0000);
        @(posedge clk); #1;
        cpu_read        = 1'b1;
        cpu_address     = 16'h0008;
        mem_input_ready = 1'b1;
        @(posedge clk); #1;
        mem_input_ready = 1'b1;
        #4;
        check_eq("rstw_req_mem_read", 64'(mem_read), 64'd1);
        @(posedge clk); #1;
        mem_input_ready = 1'b0;
        #4;
        check_eq("rstw_wait_mem_read", 64'(mem_read), 64'd0);
        @(posedge clk); #1;
        reset    = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_data  = {$urandom, $urandom};
        ref_clear();
        ref_access = 16'd0;
        ref_miss   = 16'd0;
        #4;
        check_counters("rstw");
        check_eq("rstw_mem_address", 64'(mem_address), 64'd0);
        check_eq("rstw_cpu_ready",   64'(cpu_ready),   64'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #4;
        check_eq("rstw_after_mem_read",  64'(mem_read),  64'd0);
        check_eq("rstw_after_cpu_ready", 64'(cpu_ready), 64'd0);
        fetch(16'h0008, 0, 1, 1'b0, 1'b0);
        fetch(16'h0000, 1, 0, 1'b0, 1'b0);
        check_eq("rstw_miss_count", 64'(num_miss), 64'd2);
    endtask

    initial begin
        logic [15:0] a;
        for (int i = 0; i < 16384; i++) mem_lines[i] = {$urandom, $urandom};
        mem_lines[0] = 64'h4444_3333_2222_1111;
        ref_clear();
        ref_access      = 16'd0;
        ref_miss        = 16'd0;
        reset           = 1'b1;
        flush           = 1'b0;
        cpu_read        = 1'b0;
        cpu_address     = 16'h0000;
        mem_data        = 64'h0;
        mem_input_ready = 1'b0;
        mem_ready       = 1'b0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #4;
        check_eq("rst_cpu_ready",   64'(cpu_ready),   64'd0);
        check_eq("rst_cpu_data",    64'(cpu_data),    64'd0);
        check_eq("rst_mem_read",    64'(mem_read),    64'd0);
        check_eq("rst_mem_address", 64'(mem_address), 64'd0);
        check_counters("rst");

        // Cold miss, spatial hits, conflict eviction, backpressure.
        fetch(16'h0000, 0, 2, 1'b0, 1'b0);
        check_eq("cold_access", 64'(num_access), 64'd1);
        check_eq("cold_miss",   64'(num_miss),   64'd1);
        fetch(16'h0001, 0, 0, 1'b0, 1'b0);
        fetch(16'h0002, 0, 0, 1'b0, 1'b0);
        fetch(16'h0003, 0, 0, 1'b0, 1'b0);
        check_eq("spatial_access", 64'(num_access), 64'd4);
        check_eq("spatial_miss",   64'(num_miss),   64'd1);
        fetch(16'h0010, 0, 1, 1'b0, 1'b0);
        fetch(16'h0000, 0, 1, 1'b0, 1'b0);
        check_eq("conflict_miss", 64'(num_miss), 64'd3);
        fetch(16'h0024, 5, 1, 1'b0, 1'b0);

        // Flush in IDLE, then flush during WAIT.
        flush_idle(16'h0001);
        fetch(16'h0001, 0, 0, 1'b0, 1'b0);
        check_eq("flush_refetch_miss", 64'(num_miss), 64'd5);
        fetch(16'h0008, 0, 1, 1'b0, 1'b1);
        fetch(16'h0009, 0, 0, 1'b0, 1'b0);
        check_eq("flush_wait_miss", 64'(num_miss), 64'd7);

        // Dropped fetch: refill completes without an access.
        fetch(16'h0030, 1, 1, 1'b1, 1'b0);
        fetch(16'h0031, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            a = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 16'h8000;
            if ($urandom_range(0, 14) == 0) begin
                flush_idle(a);
            end else begin
                fetch(a, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            end
        end

        reset_mid_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
